// File: rtl/byte_decode_stream_if.sv
// Byte-in / coefficient-out stream bundle for byte_decode_stream.
// slave is the decoder's view, master the producer/consumer side.
interface byte_decode_stream_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_coeff;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_coeff, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_coeff, m_valid, m_last
    );
endinterface

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_D: unpacks LSB-first bytes into D-bit coefficients,
// reducing mod Q when D==12. Fill and emit phases never overlap.
module byte_decode_stream #(
    parameter int D = 12,
    parameter int Q = 3329
) (
    input  logic                 clk,
    input  logic                 rst,
    byte_decode_stream_if.slave  bus
);
    localparam int BW = D + 7;
    localparam int CW = $clog2(D + 8);
    localparam logic [CW-1:0] DC = CW'(D);
    localparam logic [CW-1:0] EIGHT = CW'(8);
    localparam logic [15:0] QC = 16'(Q);

    logic [BW-1:0] bit_buf;
    logic [BW-1:0] buf_nx;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] cnt_nx;
    logic [7:0]    coef_cnt;
    logic [7:0]    coef_nx;
    logic          fill;
    logic          emit;
    logic [15:0]   raw;
    logic [15:0]   red;

    assign fill = (bit_cnt < DC);
    assign emit = !fill;

    // State register: bit buffer, buffered bit count, coefficient index
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_buf  <= '0;
            bit_cnt  <= '0;
            coef_cnt <= '0;
        end else begin
            bit_buf  <= buf_nx;
            bit_cnt  <= cnt_nx;
            coef_cnt <= coef_nx;
        end
    end

    // Next state: append a byte while filling, shift out D bits on a pop
    always_comb begin
        buf_nx  = bit_buf;
        cnt_nx  = bit_cnt;
        coef_nx = coef_cnt;
        if (fill && bus.s_valid) begin
            buf_nx = bit_buf | (BW'(bus.s_data) << bit_cnt);
            cnt_nx = bit_cnt + EIGHT;
        end else if (emit && bus.m_ready) begin
            buf_nx  = bit_buf >> D;
            cnt_nx  = bit_cnt - DC;
            coef_nx = coef_cnt + 8'd1;
        end
    end

    // Output decode: raw < 2Q, so one conditional subtraction reduces it
    always_comb begin
        raw = 16'(bit_buf[D-1:0]);
        red = raw;
        if (D == 12 && raw >= QC) begin
            red = raw - QC;
        end
        bus.s_ready = !rst && fill;
        bus.m_valid = !rst && emit;
        bus.m_coeff = rst ? 16'd0 : red;
        bus.m_last  = !rst && emit && (coef_cnt == 8'hFF);
    end
endmodule

// File: tb/tb_byte_decode_stream.sv
// Scoreboard bench for byte_decode_stream (D=12 main instance, D=1 side
// instance). Expected coefficients are queued as bytes are accepted.
module tb_byte_decode_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;

    byte_decode_stream_if b12 ();
    byte_decode_stream_if b1 ();

    byte_decode_stream #(.D(12), .Q(3329)) u12 (
        .clk (clk),
        .rst (rst),
        .bus (b12)
    );

    byte_decode_stream #(.D(1), .Q(3329)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nlast  = 0;

    logic [16:0] sb [$];
    logic [31:0] acc;
    int          nbits;
    int          mcnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        acc   = 0;
        nbits = 0;
        mcnt  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] r;
        acc   = acc | (32'(b) << nbits);
        nbits = nbits + 8;
        while (nbits >= 12) begin
            r     = acc & 32'hFFF;
            acc   = acc >> 12;
            nbits = nbits - 12;
            if (r >= 32'd3329) r = r - 32'd3329;
            sb.push_back({(mcnt == 255), r[15:0]});
            mcnt = (mcnt + 1) % 256;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [7:0] b);
        bit hs;
        hs = 1'b0;
        b12.s_data  = b;
        b12.s_valid = 1'b1;
        for (int k = 0; k < 200 && !hs; k++) begin
            @(negedge clk);
            hs = b12.s_ready;
            @(posedge clk);
        end
        #1;
        b12.s_valid = 1'b0;
        b12.s_data  = 8'($urandom);
        if (!hs) chk("send_timeout", 0, 1);
        else model_byte(b);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        tick();
        rst         = 1'b1;
        b12.s_valid = 1'b1;
        b12.s_data  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mvalid", b12.m_valid, 0);
            chk("rst_sready", b12.s_ready, 0);
            chk("rst_mlast", b12.m_last, 0);
            chk("rst_mcoeff", b12.m_coeff, 0);
            chk("rst_mvalid1", b1.m_valid, 0);
        end
        tick();
        rst         = 1'b0;
        b12.s_valid = 1'b0;
        model_clear();
        sb.delete();
        @(negedge clk);
        chk("post_rst_sready", b12.s_ready, 1);
        chk("post_rst_mvalid", b12.m_valid, 0);
        tick();
    endtask

    // Scoreboard: compare every popped coefficient with the queue head
    always @(negedge clk) begin
        if (b12.m_valid && b12.m_ready) begin
            if (b12.m_last) nlast++;
            if (sb.size() == 0) begin
                chk("unexpected_pop", 1, 0);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                chk("coeff", b12.m_coeff, e[15:0]);
                chk("last", b12.m_last, e[16]);
            end
        end
    end

    initial begin
        logic [7:0] pat;
        logic [15:0] held;
        bit hs;
        b12.s_data  = 8'h00;
        b12.s_valid = 1'b0;
        b12.m_ready = 1'b1;
        b1.s_data   = 8'h00;
        b1.s_valid  = 1'b0;
        b1.m_ready  = 1'b1;
        model_clear();
        do_reset();

        // Basic D=12 unpack and one-cycle latency
        send(8'h01);
        send(8'h20);
        @(negedge clk);
        chk("lat_c0", b12.m_valid, 1);
        tick();
        send(8'h00);
        @(negedge clk);
        chk("lat_c1", b12.m_valid, 1);
        tick();
        drain();

        // Reduction: 4095 -> 766, 3329 -> 0
        tick();
        foreach (pat[i]) begin end
        send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'h01); send(8'h0D); send(8'h00);
        drain();

        // Backpressure holds the pending coefficient
        tick();
        b12.m_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        repeat (10) begin
            @(negedge clk);
            chk("bp_mvalid", b12.m_valid, 1);
            chk("bp_sready", b12.s_ready, 0);
            chk("bp_coeff", b12.m_coeff, sb[0][15:0]);
            chk("bp_sbsize", sb.size(), 1);
        end
        held = b12.m_coeff;
        tick();
        b12.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_held", held, 16'h211);
        @(negedge clk);
        chk("bp_one_pop", b12.m_valid, 0);
        chk("bp_sready_back", b12.s_ready, 1);
        chk("bp_sb_empty", sb.size(), 0);
        tick();
        send(8'h33);
        drain();

        // D=1 side instance: A5 -> 1,0,1,0,0,1,0,1
        pat = 8'hA5;
        tick();
        b1.s_data  = pat;
        b1.s_valid = 1'b1;
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge clk);
            hs = b1.s_ready;
            @(posedge clk);
        end
        #1;
        b1.s_valid = 1'b0;
        chk("d1_accept", hs, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("d1_mvalid", b1.m_valid, 1);
            chk("d1_sready", b1.s_ready, 0);
            chk("d1_coeff", b1.m_coeff, 32'(pat[i]));
        end
        @(negedge clk);
        chk("d1_done", b1.m_valid, 0);
        chk("d1_sready_back", b1.s_ready, 1);

        // Two back-to-back random frames
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 384; i++) begin
                if ($urandom_range(0, 7) == 0) tick();
                send(8'($urandom));
            end
        end
        drain();

        // Reset mid-frame, then a fresh frame
        tick();
        for (int i = 0; i < 100; i++) send(8'($urandom));
        drain();
        do_reset();
        for (int i = 0; i < 384; i++) send(8'($urandom));
        drain();

        chk("nlast", nlast, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
